// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (P, H) and the RAM.
// slave  : arbiter view (takes requests, drives grants, read returns and the RAM port)
// master : environment view (requesters and RAM)
interface dmem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          p_req;
   logic [AW-1:0] p_addr;
   logic          p_wr;
   logic [DW-1:0] p_wdata;
   logic          p_gnt;
   logic          p_rvalid;
   logic [DW-1:0] p_rdata;

   logic          h_req;
   logic [AW-1:0] h_addr;
   logic          h_wr;
   logic [DW-1:0] h_wdata;
   logic          h_lock;
   logic          h_gnt;
   logic          h_rvalid;
   logic [DW-1:0] h_rdata;

   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_q;

   modport slave (
      input  p_req, p_addr, p_wr, p_wdata,
      input  h_req, h_addr, h_wr, h_wdata, h_lock,
      input  mem_q,
      output p_gnt, p_rvalid, p_rdata,
      output h_gnt, h_rvalid, h_rdata,
      output mem_addr, mem_wr, mem_wdata
   );

   modport master (
      output p_req, p_addr, p_wr, p_wdata,
      output h_req, h_addr, h_wr, h_wdata, h_lock,
      output mem_q,
      input  p_gnt, p_rvalid, p_rdata,
      input  h_gnt, h_rvalid, h_rdata,
      input  mem_addr, mem_wr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port synchronous RAM between
// the processor port (P) and the host loader/debug port (H). One access per cycle,
// same-cycle grant, read data returned one cycle after the grant.
//
// Optional host lock, enabled by defining ARB_LOCK_EN:
//   state  | meaning
//   ARB    | normal round-robin between P and H
//   LOCK_H | host owns the RAM; P is never granted, up to MAX_LOCK host grants
// Without ARB_LOCK_EN, h_lock is ignored and there is no lock state or counter.
module dmem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int MAX_LOCK = 16
) (
   input logic           clock,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   localparam logic RR_P = 1'b0;
   localparam logic RR_H = 1'b1;

   logic rr_last;
   logic p_win;
   logic h_win;
   logic lock_h;
   logic p_rvalid_q;
   logic h_rvalid_q;

`ifdef ARB_LOCK_EN
   localparam int LW = $clog2(MAX_LOCK + 1);

   typedef enum logic {ARB, LOCK_H} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [LW-1:0] lock_cnt_q;
   logic [LW-1:0] lock_cnt_d;

   // lock FSM state and grant counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ARB;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // lock entry on a locked host grant; exit on lock release or after MAX_LOCK grants
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         ARB: begin
            // with MAX_LOCK=1 the entering grant already exhausts the budget
            if (h_win && bus.h_lock && (MAX_LOCK > 1)) begin
               state_d    = LOCK_H;
               lock_cnt_d = LW'(1);
            end
         end
         LOCK_H: begin
            if (!bus.h_lock) begin
               state_d = ARB;
            end else if (h_win) begin
               lock_cnt_d = lock_cnt_q + LW'(1);
               if (int'(lock_cnt_q) + 1 >= MAX_LOCK) state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   assign lock_h = (state_q == LOCK_H);
`else
   logic unused_cfg;
   assign unused_cfg = bus.h_lock & (MAX_LOCK >= 1);
   assign lock_h     = 1'b0;
`endif

   // pick the winner; nothing is granted while reset is held
   always_comb begin
      p_win = 1'b0;
      h_win = 1'b0;
      if (!reset) begin
         if (lock_h) begin
            h_win = bus.h_req;
         end else if (bus.p_req && bus.h_req) begin
            p_win = (rr_last == RR_H);
            h_win = (rr_last == RR_P);
         end else begin
            p_win = bus.p_req;
            h_win = bus.h_req;
         end
      end
   end

   // RAM port carries the winner's fields, idle-zero otherwise so no write leaks out
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wr    = 1'b0;
      bus.mem_wdata = '0;
      if (p_win) begin
         bus.mem_addr  = bus.p_addr;
         bus.mem_wr    = bus.p_wr;
         bus.mem_wdata = bus.p_wdata;
      end else if (h_win) begin
         bus.mem_addr  = bus.h_addr;
         bus.mem_wr    = bus.h_wr;
         bus.mem_wdata = bus.h_wdata;
      end
   end

   // remember the last winner; reset to H so P wins the first tie
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_last <= RR_H;
      end else if (p_win) begin
         rr_last <= RR_P;
      end else if (h_win) begin
         rr_last <= RR_H;
      end
   end

   // read-return flags, one cycle behind a granted read; reset drops any pending one
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p_rvalid_q <= 1'b0;
         h_rvalid_q <= 1'b0;
      end else begin
         p_rvalid_q <= p_win & ~bus.p_wr;
         h_rvalid_q <= h_win & ~bus.h_wr;
      end
   end

   assign bus.p_gnt    = p_win;
   assign bus.h_gnt    = h_win;
   assign bus.p_rvalid = p_rvalid_q;
   assign bus.h_rvalid = h_rvalid_q;
   assign bus.p_rdata  = bus.mem_q;
   assign bus.h_rdata  = bus.mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model (shadow memory,
// last-winner flag, pending-read slots).
module tb_dmem_arbiter;

   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int MAXL = 4;

   logic clock = 1'b0;
   logic reset;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAXL)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] ram    [256];
   logic [DW-1:0] shadow [256];

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 'h10) return 16'hBEEF;
      return 16'(i * 16'h0123 + 7);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // synchronous RAM behind the arbiter
   initial begin
      for (int i = 0; i < 256; i++) ram[i] = init_val(i);
      forever begin
         @(posedge clock);
         if (bus.mem_wr === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_q <= ram[bus.mem_addr];
      end
   end

   // reference model + per-cycle compare, sampled at the falling edge
   logic          m_last_h;
   logic          m_prv, m_hrv;
   logic [DW-1:0] m_prd, m_hrd;
   logic          m_locked;
   int            m_used;
   logic          ep, eh;
   logic [AW-1:0] ea;
   logic          ew;
   logic [DW-1:0] ed;

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      m_last_h = 1'b1; m_prv = 1'b0; m_hrv = 1'b0; m_prd = '0; m_hrd = '0;
      m_locked = 1'b0; m_used = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            chk("rst_p_gnt",    32'(bus.p_gnt),    0);
            chk("rst_h_gnt",    32'(bus.h_gnt),    0);
            chk("rst_mem_wr",   32'(bus.mem_wr),   0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 0);
            chk("rst_mem_wdat", 32'(bus.mem_wdata), 0);
            chk("rst_p_rvalid", 32'(bus.p_rvalid), 0);
            chk("rst_h_rvalid", 32'(bus.h_rvalid), 0);
            m_last_h = 1'b1; m_prv = 1'b0; m_hrv = 1'b0; m_locked = 1'b0; m_used = 0;
         end else begin
            chk("p_rvalid", 32'(bus.p_rvalid), 32'(m_prv));
            if (m_prv) chk("p_rdata", 32'(bus.p_rdata), 32'(m_prd));
            chk("h_rvalid", 32'(bus.h_rvalid), 32'(m_hrv));
            if (m_hrv) chk("h_rdata", 32'(bus.h_rdata), 32'(m_hrd));

            ep = 1'b0; eh = 1'b0;
`ifdef ARB_LOCK_EN
            if (m_locked) eh = bus.h_req;
            else
`endif
            begin
               if (bus.p_req && bus.h_req) begin
                  ep = m_last_h; eh = !m_last_h;
               end else begin
                  ep = bus.p_req; eh = bus.h_req;
               end
            end
            ea = '0; ew = 1'b0; ed = '0;
            if (ep) begin ea = bus.p_addr; ew = bus.p_wr; ed = bus.p_wdata; end
            if (eh) begin ea = bus.h_addr; ew = bus.h_wr; ed = bus.h_wdata; end

            chk("p_gnt",     32'(bus.p_gnt),     32'(ep));
            chk("h_gnt",     32'(bus.h_gnt),     32'(eh));
            chk("mem_addr",  32'(bus.mem_addr),  32'(ea));
            chk("mem_wr",    32'(bus.mem_wr),    32'(ew));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));

            m_prv = ep && !bus.p_wr;
            m_hrv = eh && !bus.h_wr;
            if (ep || eh) begin
               m_prd = shadow[ea]; m_hrd = shadow[ea];
               if (ew) shadow[ea] = ed;
               m_last_h = eh;
            end
`ifdef ARB_LOCK_EN
            if (m_locked) begin
               if (eh) m_used++;
               if (!bus.h_lock || m_used >= MAXL) m_locked = 1'b0;
            end else if (eh && bus.h_lock) begin
               m_used = 1; m_locked = (MAXL > 1);
            end
`endif
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      bus.p_req = 1'b0; bus.p_addr = '0; bus.p_wr = 1'b0; bus.p_wdata = '0;
      bus.h_req = 1'b0; bus.h_addr = '0; bus.h_wr = 1'b0; bus.h_wdata = '0;
      bus.h_lock = 1'b0;
   endtask

   task automatic apply_reset();
      step();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   logic pg, hg;
   int   bad;

   initial begin
      reset = 1'b1;
      idle_inputs();
      bus.p_req = 1'b1; bus.p_addr = 8'h10;

      // 1: single P read right after reset release
      at_neg();
      chk("t1_rst_gnt", 32'(bus.p_gnt), 0);
      step();
      reset = 1'b0;
      at_neg();
      chk("t1_p_gnt",    32'(bus.p_gnt),    1);
      chk("t1_h_gnt",    32'(bus.h_gnt),    0);
      chk("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
      step();
      bus.p_req = 1'b0;
      at_neg();
      chk("t1_p_rvalid", 32'(bus.p_rvalid), 1);
      chk("t1_p_rdata",  32'(bus.p_rdata),  32'hBEEF);
      chk("t1_h_gnt2",   32'(bus.h_gnt),    0);

      // 2: both request continuously from reset -> P,H,P,H
      apply_reset();
      bus.p_req = 1'b1; bus.p_addr = 8'h21;
      bus.h_req = 1'b1; bus.h_addr = 8'h42;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("t2_p_gnt",    32'(bus.p_gnt),    (i % 2 == 0) ? 1 : 0);
         chk("t2_h_gnt",    32'(bus.h_gnt),    (i % 2 == 1) ? 1 : 0);
         chk("t2_mem_addr", 32'(bus.mem_addr), (i % 2 == 0) ? 32'h21 : 32'h42);
         step();
      end
      idle_inputs();

      // 3: H writes 0x05, P reads it back the next cycle
      bus.h_req = 1'b1; bus.h_wr = 1'b1; bus.h_addr = 8'h05; bus.h_wdata = 16'h1234;
      at_neg();
      chk("t3_h_gnt",     32'(bus.h_gnt),     1);
      chk("t3_mem_wr",    32'(bus.mem_wr),    1);
      chk("t3_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      step();
      idle_inputs();
      bus.p_req = 1'b1; bus.p_addr = 8'h05;
      at_neg();
      chk("t3_p_gnt",    32'(bus.p_gnt),    1);
      chk("t3_h_rvalid", 32'(bus.h_rvalid), 0);
      step();
      idle_inputs();
      at_neg();
      chk("t3_p_rvalid",  32'(bus.p_rvalid), 1);
      chk("t3_p_rdata",   32'(bus.p_rdata),  32'h1234);
      chk("t3_h_rvalid2", 32'(bus.h_rvalid), 0);

      // 4: reset the cycle after a P read grant
      step();
      bus.p_req = 1'b1; bus.p_addr = 8'h10;
      at_neg();
      chk("t4_p_gnt", 32'(bus.p_gnt), 1);
      step();
      reset = 1'b1;
      bus.h_req = 1'b1; bus.h_addr = 8'h42;
      at_neg();
      chk("t4_p_rvalid",  32'(bus.p_rvalid),  0);
      chk("t4_p_gnt_rst", 32'(bus.p_gnt),     0);
      chk("t4_h_gnt_rst", 32'(bus.h_gnt),     0);
      chk("t4_mem_addr",  32'(bus.mem_addr),  0);
      chk("t4_mem_wr",    32'(bus.mem_wr),    0);
      step();
      reset = 1'b0;
      at_neg();
      chk("t4_p_first",  32'(bus.p_gnt),    1);
      chk("t4_h_first",  32'(bus.h_gnt),    0);
      chk("t4_no_late",  32'(bus.p_rvalid), 0);
      step();
      at_neg();
      chk("t4_h_second", 32'(bus.h_gnt),    1);
      step();
      idle_inputs();

`ifdef ARB_LOCK_EN
      // 5: host lock with MAX_LOCK=4 -> H x4, then P, then H
      apply_reset();
      bus.p_req = 1'b1; bus.p_addr = 8'h10;
      at_neg();
      step();
      bus.h_req = 1'b1; bus.h_lock = 1'b1; bus.h_addr = 8'h33;
      for (int i = 0; i < 6; i++) begin
         at_neg();
         chk("t5_h_gnt", 32'(bus.h_gnt), (i == 4) ? 0 : 1);
         chk("t5_p_gnt", 32'(bus.p_gnt), (i == 4) ? 1 : 0);
         step();
      end
      idle_inputs();
`endif

      // 6: ten idle cycles, no activity and no RAM change
      step();
      for (int i = 0; i < 10; i++) begin
         at_neg();
         chk("t6_mem_wr",  32'(bus.mem_wr), 0);
         chk("t6_any_gnt", 32'(bus.p_gnt | bus.h_gnt), 0);
         chk("t6_rvalid",  32'(bus.p_rvalid | bus.h_rvalid), 0);
         step();
      end

      // random traffic: hold until grant, occasional cancel, small address window
      for (int c = 0; c < 4000; c++) begin
         at_neg();
         pg = bus.p_gnt; hg = bus.h_gnt;
         step();
         if (bus.p_req && !pg && $urandom_range(7) == 0) begin
            bus.p_req = 1'b0;
         end else if (!bus.p_req || pg) begin
            bus.p_req = ($urandom_range(3) != 0);
            bus.p_addr = 8'($urandom_range(15));
            bus.p_wr = 1'($urandom_range(1));
            bus.p_wdata = 16'($urandom);
         end
         if (bus.h_req && !hg && $urandom_range(7) == 0) begin
            bus.h_req = 1'b0;
         end else if (!bus.h_req || hg) begin
            bus.h_req = ($urandom_range(3) != 0);
            bus.h_addr = 8'($urandom_range(15));
            bus.h_wr = 1'($urandom_range(1));
            bus.h_wdata = 16'($urandom);
            bus.h_lock = ($urandom_range(3) == 0);
         end
      end
      idle_inputs();
      step();
      step();
      step();

      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) bad++;
      chk("ram_contents", 32'(bad), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
